// File: rtl/spi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_bridge
// Description : Replays the I2C target's received write bytes as SPI mode-0
//               master frames; the first byte of each write selects the CS.
//               Optional MISO capture is built when SPI_MISO_CAPTURE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_bridge #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CS     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              byte_valid,
  input  logic              is_addr_byte,
  input  logic              bus_active,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        miso_byte,
  output logic              miso_valid
);

  // The select field is wide enough to encode NUM_CS itself, so an out-of-range
  // select (e.g. 0x02 with two chip selects) is recognised and discarded.
  localparam int c_selw = $clog2(NUM_CS + 1);
  localparam int c_aw   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cw   = $clog2(FIFO_DEPTH + 1);
  localparam int c_dw   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_SETUP = 3'd2,
    S_SHIFT = 3'd3,
    S_GAP   = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  // ---------------------------------------------------------------- byte FIFO
  logic [8:0]      r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_cw-1:0] r_count;
  logic            r_overflow;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [8:0]      w_head;
  logic            w_have_data;
  logic            w_have_ctrl;

  assign w_full      = (r_count == c_cw'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_have_data = !w_empty && !w_head[8];
  assign w_have_ctrl = !w_empty &&  w_head[8];
  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign w_push      = byte_valid && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {is_addr_byte, rx_byte};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_push && is_addr_byte) begin
        r_overflow <= 1'b0;
      end else if (byte_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- SPI engine
  state_t            r_state,   nxt_state;
  logic [c_dw-1:0]   r_div_cnt, nxt_div_cnt;
  logic [2:0]        r_bit_cnt, nxt_bit_cnt;
  logic              r_sck,     nxt_sck;
  logic              r_mosi,    nxt_mosi;
  logic [NUM_CS-1:0] r_cs_n,    nxt_cs_n;
  logic [7:0]        r_sh,      nxt_sh;
  logic [c_selw-1:0] r_sel,     nxt_sel;
  logic              r_discard, nxt_discard;
  logic              r_hold_hi, nxt_hold_hi;
  logic              w_div_end;
  logic              w_rise;
  logic              w_byte_done;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [c_selw-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == c_selw'(i)) begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  assign w_div_end = (r_div_cnt == c_dw'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= '1;
      r_sh      <= '0;
      r_sel     <= '0;
      r_discard <= 1'b0;
      r_hold_hi <= 1'b0;
    end else begin
      r_state   <= nxt_state;
      r_div_cnt <= nxt_div_cnt;
      r_bit_cnt <= nxt_bit_cnt;
      r_sck     <= nxt_sck;
      r_mosi    <= nxt_mosi;
      r_cs_n    <= nxt_cs_n;
      r_sh      <= nxt_sh;
      r_sel     <= nxt_sel;
      r_discard <= nxt_discard;
      r_hold_hi <= nxt_hold_hi;
    end
  end

  always_comb begin
    nxt_state   = r_state;
    nxt_div_cnt = r_div_cnt;
    nxt_bit_cnt = r_bit_cnt;
    nxt_sck     = r_sck;
    nxt_mosi    = r_mosi;
    nxt_cs_n    = r_cs_n;
    nxt_sh      = r_sh;
    nxt_sel     = r_sel;
    nxt_discard = r_discard;
    nxt_hold_hi = r_hold_hi;
    w_pop       = 1'b0;
    w_rise      = 1'b0;
    w_byte_done = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head[8]) begin
            nxt_sel     = w_head[c_selw-1:0];
            nxt_discard = (32'(w_head[c_selw-1:0]) >= 32'(NUM_CS));
            nxt_state   = S_SEL;
          end
        end
      end

      S_SEL: begin
        if (w_have_ctrl) begin
          w_pop       = 1'b1;
          nxt_sel     = w_head[c_selw-1:0];
          nxt_discard = (32'(w_head[c_selw-1:0]) >= 32'(NUM_CS));
        end else if (w_have_data) begin
          w_pop = 1'b1;
          if (!r_discard) begin
            nxt_cs_n    = cs_decode(r_sel);
            nxt_sh      = w_head[7:0];
            nxt_mosi    = w_head[7];
            nxt_div_cnt = '0;
            nxt_state   = S_SETUP;
          end
        end else if (!bus_active) begin
          nxt_state = S_IDLE;
        end
      end

      S_SETUP: begin
        if (w_div_end) begin
          nxt_div_cnt = '0;
          nxt_bit_cnt = '0;
          nxt_sck     = 1'b1;
          w_rise      = 1'b1;
          nxt_state   = S_SHIFT;
        end else begin
          nxt_div_cnt = r_div_cnt + 1'b1;
        end
      end

      S_SHIFT: begin
        if (!w_div_end) begin
          nxt_div_cnt = r_div_cnt + 1'b1;
        end else begin
          nxt_div_cnt = '0;
          if (!r_sck) begin
            nxt_sck = 1'b1;
            w_rise  = 1'b1;
          end else begin
            nxt_sck = 1'b0;
            if (r_bit_cnt != 3'd7) begin
              nxt_bit_cnt = r_bit_cnt + 1'b1;
              nxt_sh      = {r_sh[6:0], 1'b0};
              nxt_mosi    = r_sh[6];
            end else begin
              w_byte_done = 1'b1;
              // Queued data continues the frame with no extra SCK-low time.
              if (w_have_data) begin
                w_pop       = 1'b1;
                nxt_sh      = w_head[7:0];
                nxt_mosi    = w_head[7];
                nxt_bit_cnt = '0;
              end else if (w_empty && bus_active) begin
                nxt_state = S_GAP;
              end else begin
                nxt_hold_hi = 1'b0;
                nxt_state   = S_HOLD;
              end
            end
          end
        end
      end

      S_GAP: begin
        if (w_have_data) begin
          w_pop       = 1'b1;
          nxt_sh      = w_head[7:0];
          nxt_mosi    = w_head[7];
          nxt_div_cnt = '0;
          nxt_state   = S_SETUP;
        end else if (w_have_ctrl || !bus_active) begin
          nxt_div_cnt = '0;
          nxt_hold_hi = 1'b0;
          nxt_state   = S_HOLD;
        end
      end

      S_HOLD: begin
        if (!w_div_end) begin
          nxt_div_cnt = r_div_cnt + 1'b1;
        end else begin
          nxt_div_cnt = '0;
          if (!r_hold_hi) begin
            nxt_hold_hi = 1'b1;
            nxt_cs_n    = '1;
          end else begin
            nxt_mosi  = 1'b0;
            nxt_state = S_IDLE;
          end
        end
      end

      default: begin
        nxt_cs_n  = '1;
        nxt_sck   = 1'b0;
        nxt_state = S_IDLE;
      end
    endcase
  end

  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;
  assign busy     = (r_state != S_IDLE) || !w_empty;
  assign overflow = r_overflow;

`ifdef SPI_MISO_CAPTURE_EN
  logic [7:0] r_miso_sh;
  logic [7:0] r_miso_byte;
  logic       r_miso_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miso_sh    <= '0;
      r_miso_byte  <= '0;
      r_miso_valid <= 1'b0;
    end else begin
      r_miso_valid <= w_byte_done;
      if (w_rise) begin
        r_miso_sh <= {r_miso_sh[6:0], spi_miso};
      end
      if (w_byte_done) begin
        r_miso_byte <= r_miso_sh;
      end
    end
  end

  assign miso_byte  = r_miso_byte;
  assign miso_valid = r_miso_valid;
`else
  logic w_unused;
  assign w_unused   = ^{spi_miso, w_rise, w_byte_done};
  assign miso_byte  = 8'h00;
  assign miso_valid = 1'b0;
`endif

endmodule
`default_nettype wire
